// File: rtl/crank_wheel_gen_if.sv
// Trigger-wheel generator control/observation bundle.
//   master : drives run request, tooth period and wheel geometry (N, M);
//            observes the generated waveform and status.
//   slave  : the generator side (crank_wheel_gen).
// Signals:
//   enable                 run request, level sensitive
//   tooth_period           clocks per tooth pitch
//   trigger_tooth_cnt      N, tooth positions per revolution incl. missing
//   trigger_teeth_missing  M, consecutive missing teeth at end of revolution
//   vrout                  generated trigger waveform
//   tooth_index            current slot position 0..N-1
//   rev_pulse              one-cycle strobe at start of slot 0
//   running                generator active
//   config_err             idle because the sampled config is invalid
interface crank_wheel_gen_if #(
  parameter int unsigned PERIOD_W = 32
) ();
  logic                enable;
  logic [PERIOD_W-1:0] tooth_period;
  logic [15:0]         trigger_tooth_cnt;
  logic [15:0]         trigger_teeth_missing;
  logic                vrout;
  logic [15:0]         tooth_index;
  logic                rev_pulse;
  logic                running;
  logic                config_err;

  modport master (
    output enable, tooth_period, trigger_tooth_cnt, trigger_teeth_missing,
    input  vrout, tooth_index, rev_pulse, running, config_err
  );

  modport slave (
    input  enable, tooth_period, trigger_tooth_cnt, trigger_teeth_missing,
    output vrout, tooth_index, rev_pulse, running, config_err
  );
endinterface

// File: rtl/crank_wheel_gen.sv
// Missing-tooth (N-M) crank trigger waveform generator.
// Each slot lasts P clocks; real teeth are high for floor(P/2) clocks, the
// last M slots of a revolution stay low. Period and geometry are shadowed and
// only reloaded when leaving IDLE or at the wrap into slot 0.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    crank_wheel_gen_if.slave (enable, tooth_period, N, M in;
//          vrout, tooth_index, rev_pulse, running, config_err out)
module crank_wheel_gen #(
  parameter int unsigned PERIOD_W   = 32,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  crank_wheel_gen_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         m_q, m_d;
  logic [15:0]         idx_q, idx_d;
  logic                vrout_q, vrout_d;
  logic                rev_q, rev_d;
  logic                run_q, run_d;
  logic                err_q, err_d;

  logic                live_valid;
  logic [PERIOD_W-1:0] high_time;
  logic [PERIOD_W-1:0] last_cnt;
  logic [PERIOD_W-1:0] cnt_next;
  logic [15:0]         real_cnt;
  logic [15:0]         idx_next;

  // M <= N-2 evaluated in 17 bits so small N cannot underflow.
  assign live_valid = ({1'b0, bus.trigger_tooth_cnt} >= 17'd2) &&
                      (({1'b0, bus.trigger_teeth_missing} + 17'd2) <=
                       {1'b0, bus.trigger_tooth_cnt}) &&
                      (bus.tooth_period >= PERIOD_W'(MIN_PERIOD));

  assign high_time = per_q >> 1;
  assign last_cnt  = per_q - PERIOD_W'(1);
  assign cnt_next  = cnt_q + PERIOD_W'(1);
  assign real_cnt  = n_q - m_q;
  assign idx_next  = idx_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      n_q     <= '0;
      m_q     <= '0;
      idx_q   <= '0;
      vrout_q <= 1'b0;
      rev_q   <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      n_q     <= n_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      vrout_q <= vrout_d;
      rev_q   <= rev_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  // Outputs are computed for the *next* cycle's count/index so that the
  // registered vrout lines up with the slot counter it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    n_d     = n_q;
    m_d     = m_q;
    idx_d   = idx_q;
    vrout_d = 1'b0;
    rev_d   = 1'b0;
    run_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.enable) begin
          if (live_valid) begin
            per_d   = bus.tooth_period;
            n_d     = bus.trigger_tooth_cnt;
            m_d     = bus.trigger_teeth_missing;
            state_d = HIGH;
            vrout_d = 1'b1;
            rev_d   = 1'b1;
            run_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HIGH, LOW: begin
        if (!bus.enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == last_cnt) begin
          cnt_d = '0;
          if (idx_q == n_q - 16'd1) begin
            idx_d = '0;
            if (live_valid) begin
              // Slot 0 is always a real tooth since M <= N-2.
              per_d   = bus.tooth_period;
              n_d     = bus.trigger_tooth_cnt;
              m_d     = bus.trigger_teeth_missing;
              state_d = HIGH;
              vrout_d = 1'b1;
              rev_d   = 1'b1;
              run_d   = 1'b1;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_next;
            run_d   = 1'b1;
            vrout_d = (idx_next < real_cnt);
            state_d = vrout_d ? HIGH : LOW;
          end
        end else begin
          // LOW never returns to HIGH mid-slot, so HIGH also marks a real tooth.
          cnt_d   = cnt_next;
          run_d   = 1'b1;
          vrout_d = (state_q == HIGH) && (cnt_next < high_time);
          state_d = vrout_d ? HIGH : LOW;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.vrout       = vrout_q;
  assign bus.tooth_index = idx_q;
  assign bus.rev_pulse   = rev_q;
  assign bus.running     = run_q;
  assign bus.config_err  = err_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Self-checking bench for crank_wheel_gen: a cycle-stamped vector table for
// the main N=4/M=1 revolution, period change, enable drop and invalid
// configs, followed by hand-written multi-cycle sequences.
module tb_crank_wheel_gen;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  crank_wheel_gen_if #(.PERIOD_W(32)) bus ();

  crank_wheel_gen #(.PERIOD_W(32), .MIN_PERIOD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          cyc;
    logic        en;
    logic [31:0] p;
    logic [15:0] n;
    logic [15:0] m;
    logic        v;
    logic [15:0] idx;
    logic        rev;
    logic        run;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int cyc, logic en, logic [31:0] p, logic [15:0] n,
                              logic [15:0] m, logic v, logic [15:0] idx,
                              logic rev, logic run, logic err);
    vec_t r;
    r.cyc = cyc; r.en = en; r.p = p; r.n = n; r.m = m;
    r.v = v; r.idx = idx; r.rev = rev; r.run = run; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [15:0] idx,
                         input logic rev, input logic run, input logic err);
    chk({tag, ".vrout"}, {31'd0, bus.vrout}, {31'd0, v});
    chk({tag, ".idx"}, {16'd0, bus.tooth_index}, {16'd0, idx});
    chk({tag, ".rev"}, {31'd0, bus.rev_pulse}, {31'd0, rev});
    chk({tag, ".run"}, {31'd0, bus.running}, {31'd0, run});
    chk({tag, ".err"}, {31'd0, bus.config_err}, {31'd0, err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic en, input logic [31:0] p,
                         input logic [15:0] n, input logic [15:0] m);
    bus.enable                = en;
    bus.tooth_period          = p;
    bus.trigger_tooth_cnt     = n;
    bus.trigger_teeth_missing = m;
  endtask

  task automatic do_reset();
    set_cfg(1'b0, 32'd10, 16'd4, 16'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    set_cfg(1'b0, 32'd10, 16'd4, 16'd1);
    #3;
    chk_all("reset", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("idle", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

    //            cyc en  P   N  M   v idx rev run err
    tbl.push_back(mk( 1, 1, 10, 4, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk( 2, 1, 10, 4, 1,  1, 0, 0, 1, 0));
    tbl.push_back(mk( 5, 1, 10, 4, 1,  1, 0, 0, 1, 0));
    tbl.push_back(mk( 6, 1, 10, 4, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk(10, 1, 10, 4, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk(11, 1, 10, 4, 1,  1, 1, 0, 1, 0));
    tbl.push_back(mk(15, 1, 20, 4, 1,  1, 1, 0, 1, 0));
    tbl.push_back(mk(16, 1, 20, 4, 1,  0, 1, 0, 1, 0));
    tbl.push_back(mk(21, 1, 20, 4, 1,  1, 2, 0, 1, 0));
    tbl.push_back(mk(26, 1, 20, 4, 1,  0, 2, 0, 1, 0));
    tbl.push_back(mk(31, 1, 20, 4, 1,  0, 3, 0, 1, 0));
    tbl.push_back(mk(40, 1, 20, 4, 1,  0, 3, 0, 1, 0));
    tbl.push_back(mk(41, 1, 20, 4, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(42, 1, 20, 4, 1,  1, 0, 0, 1, 0));
    tbl.push_back(mk(50, 1, 20, 4, 1,  1, 0, 0, 1, 0));
    tbl.push_back(mk(51, 1, 20, 4, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk(61, 1, 20, 4, 1,  1, 1, 0, 1, 0));
    tbl.push_back(mk(81, 1, 20, 4, 1,  1, 2, 0, 1, 0));
    tbl.push_back(mk(83, 1, 20, 4, 1,  1, 2, 0, 1, 0));
    tbl.push_back(mk(84, 0, 20, 4, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(85, 1, 10, 4, 3,  0, 0, 0, 0, 1));
    tbl.push_back(mk(88, 1, 10, 4, 3,  0, 0, 0, 0, 1));
    tbl.push_back(mk(89, 1,  2, 4, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(90, 1,  3, 4, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(91, 1,  4, 4, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(92, 1,  4, 4, 1,  1, 0, 0, 1, 0));
    tbl.push_back(mk(93, 1,  4, 4, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk(95, 1,  4, 4, 1,  1, 1, 0, 1, 0));

    cyc = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      set_cfg(tbl[i].en, tbl[i].p, tbl[i].n, tbl[i].m);
      while (cyc < tbl[i].cyc) begin
        tick();
        cyc++;
      end
      chk_all($sformatf("tbl_c%0d", tbl[i].cyc), tbl[i].v, tbl[i].idx,
              tbl[i].rev, tbl[i].run, tbl[i].err);
    end

    // config_err clears once enable drops
    set_cfg(1'b0, 32'd10, 16'd4, 16'd1);
    tick();
    set_cfg(1'b1, 32'd10, 16'd4, 16'd3);
    tick();
    chk("err_set", {31'd0, bus.config_err}, 32'd1);
    set_cfg(1'b0, 32'd10, 16'd4, 16'd3);
    tick();
    chk("err_clr_en", {31'd0, bus.config_err}, 32'd0);

    // invalid config seen at the wrap stops the generator with config_err
    do_reset();
    set_cfg(1'b1, 32'd10, 16'd4, 16'd1);
    repeat (21) tick();
    set_cfg(1'b1, 32'd10, 16'd4, 16'd3);
    repeat (19) tick();
    chk_all("wrap_pre", 1'b0, 16'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("wrap_bad", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    // P=11: rises every 11 inside a revolution, (M+1)*P gap, width 5
    begin
      int rises[$];
      int widths[$];
      int revs[$];
      int w;
      logic prev;
      do_reset();
      set_cfg(1'b1, 32'd11, 16'd4, 16'd1);
      prev = 1'b0;
      w = 0;
      for (int c = 1; c <= 140; c++) begin
        tick();
        if (bus.vrout && !prev) rises.push_back(c);
        if (bus.rev_pulse) revs.push_back(c);
        if (bus.vrout) w++;
        else if (prev) begin
          widths.push_back(w);
          w = 0;
        end
        prev = bus.vrout;
      end
      chk("p11_nrises", (rises.size() >= 9) ? 32'd1 : 32'd0, 32'd1);
      chk("p11_nwidths", (widths.size() >= 9) ? 32'd1 : 32'd0, 32'd1);
      chk("p11_nrevs", revs.size(), 32'd4);
      for (int r = 0; r < 3; r++) begin
        for (int t = 0; t < 3; t++) begin
          int k;
          k = r * 3 + t;
          if (k < rises.size())
            chk($sformatf("p11_rise%0d", k), rises[k], 1 + 44 * r + 11 * t);
          if (k < widths.size())
            chk($sformatf("p11_width%0d", k), widths[k], 32'd5);
        end
      end
      for (int r = 0; r < 4; r++)
        if (r < revs.size()) chk($sformatf("p11_rev%0d", r), revs[r], 1 + 44 * r);
    end

    // smallest wheel N=2, M=0 at P=4
    do_reset();
    set_cfg(1'b1, 32'd4, 16'd2, 16'd0);
    tick();
    chk_all("n2_c1", 1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    chk_all("n2_c3", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    chk_all("n2_c5", 1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    chk_all("n2_c9", 1'b1, 16'd0, 1'b1, 1'b1, 1'b0);

    // asynchronous reset mid-slot, then clean restart at slot 0
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("post_rst", 1'b1, 16'd0, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
- Synthesises a missing-tooth crank trigger waveform (N−M wheel) from a commanded tooth period. It is the transmit side of the trigger-wheel interface consumed by `sync`.
- Used as the on-chip engine simulator for bench/HIL testing: `vrout` connects to the decoder's `vrin`, and it also drives an output pin for external ECUs.
- Wheel geometry uses the same encoding as the decoder config registers (`trigger_tooth_cnt`, `trigger_teeth_missing`), so one register set describes both ends.

Parameters:
- `PERIOD_W`, 32, width of `tooth_period` and the internal slot counter.
- `MIN_PERIOD`, 4, smallest accepted `tooth_period` in clocks.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  run request; level sensitive
- `tooth_period`  in  `PERIOD_W`  clocks per tooth pitch (rising edge to rising edge of adjacent real teeth)
- `trigger_tooth_cnt`  in  16  N, total tooth positions per revolution, including missing ones
- `trigger_teeth_missing`  in  16  M, consecutive missing teeth at the end of the revolution
- `vrout`  out  1  generated trigger waveform
- `tooth_index`  out  16  current slot position, 0..N−1
- `rev_pulse`  out  1  one-cycle strobe at the start of slot 0
- `running`  out  1  high while the generator is active
- `config_err`  out  1  high while idle because the sampled config is invalid

Behaviour:
- Reset (async assert, sync release): state IDLE. `vrout`=0, `tooth_index`=0, `rev_pulse`=0, `running`=0, `config_err`=0. Shadow config regs and slot counter are cleared.
- Config is valid when all of these hold: N≥2, M≤N−2, `tooth_period`≥`MIN_PERIOD`.
- Shadow config (P, N, M) is latched only:
  - on leaving IDLE, and
  - on each wrap from slot N−1 to slot 0.
- Input changes mid-revolution therefore take effect at the next revolution boundary, never mid-slot.
- States are IDLE, HIGH and LOW. All outputs are registered.
- IDLE:
  - `vrout`=0 and `running`=0.
  - When `enable`=1 and the live config is valid: latch shadows. Next cycle enter HIGH with `tooth_index`=0, `running`=1, `rev_pulse`=1, `vrout`=1. `vrout` therefore rises exactly 1 clock after `enable` is sampled high.
  - When `enable`=1 and the config is invalid: set `config_err`=1 and stay in IDLE. `config_err` clears the cycle after the config becomes valid or `enable` drops.
- Slot timing:
  - The slot counter runs 0..P−1; each slot lasts exactly P clocks.
  - High time H = P>>1 (floor). Low time = P−H.
  - Real tooth (index < N−M): `vrout`=1 for counts 0..H−1, then 0 for counts H..P−1.
  - Missing tooth (index ≥ N−M): `vrout`=0 for the whole slot.
- HIGH→LOW when the count reaches H.
- Slot end (count = P−1):
  - Reset the count and advance the index.
  - At index N−1, wrap to 0, reload shadows and pulse `rev_pulse`.
  - Enter HIGH if the new slot is a real tooth, otherwise stay in LOW.
- Resulting edge spacing:
  - Rising edges within the teeth are exactly P clocks apart.
  - The gap from the last real tooth's rising edge to tooth 0's rising edge is (M+1)·P clocks, matching the decoder's long-tooth window.
- `rev_pulse` is high only on the first clock of slot 0. It is coincident with the `vrout` rise of tooth 0.
- `enable` deasserted in any non-IDLE state: next cycle go to IDLE. `vrout`=0, `tooth_index`=0, `running`=0, no `rev_pulse`. Re-enable restarts at slot 0.
- A `tooth_period` change mid-revolution is ignored until the wrap. An invalid config seen at the wrap behaves as an `enable` drop plus `config_err`=1.
- Reset asserted mid-slot clears all state immediately. No partial pulse is emitted after release.
- Arithmetic:
  - The count compare uses the full `PERIOD_W` width; no overflow is possible because the count is < P.
  - The index compare uses 16 bits.

Test Plan:
- N=4, M=1, P=10, `enable` rises at cycle 0:
  - `vrout` rises at cycles 1, 11 and 21, each high for 5 clocks.
  - The next rise is at cycle 41 (gap 20).
  - `rev_pulse` is high at cycles 1 and 41 only.
  - `tooth_index` sequence is 0,1,2,3,0.
- P=11, N=4, M=1: high 5 clocks, low 6 clocks. Rising-edge spacing of 11 is held over 3 revolutions.
- Change P from 10 to 20 during slot 1: slots 1–3 keep P=10. Revolution 2 starts at the cycle-41 rise using P=20, so the next rise is at cycle 61.
- Invalid configs, each held with `enable`=1:
  - N=4, M=3 → `config_err`=1, `vrout` stays 0.
  - P=2 → `config_err`=1, `vrout` stays 0.
  - After correcting to M=1, `vrout` rises 1 cycle after the valid config is sampled.
- `enable` drop and reset mid-operation:
  - Drop `enable` mid-high of tooth 2 → `vrout` is 0 on the next cycle and `tooth_index`=0.
  - Assert `rst_n`=0 asynchronously mid-slot → outputs clear without waiting for a clock edge.
- Closed loop with `sync`: N=36, M=1, P=100, offset 0.
  - `synced` asserts after the first gap plus one tooth.
  - `eng_phase` increments by the tooth width on each tooth.
  - `synced` stays high for 10 revolutions.
  - Dropping `enable` causes `synced` to fall after the decoder timeout.
